// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_pkg
// Description : Shared types and constants for the arbitrated 4-digit
//               seven-segment display. Holds the controller state enum, the
//               digit-index type, the active-low segment patterns
//               (seg[0]=CA .. seg[6]=CG) and the round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Digit 3 is the leftmost position, digit 0 the rightmost.
    typedef logic [1:0] digit_idx_t;

    // Active-low patterns: a 0 bit lights the segment.
    localparam logic [6:0] c_seg_0     = 7'h40;
    localparam logic [6:0] c_seg_1     = 7'h79;
    localparam logic [6:0] c_seg_2     = 7'h24;
    localparam logic [6:0] c_seg_3     = 7'h30;
    localparam logic [6:0] c_seg_4     = 7'h19;
    localparam logic [6:0] c_seg_5     = 7'h12;
    localparam logic [6:0] c_seg_6     = 7'h02;
    localparam logic [6:0] c_seg_7     = 7'h78;
    localparam logic [6:0] c_seg_8     = 7'h00;
    localparam logic [6:0] c_seg_9     = 7'h10;
    localparam logic [6:0] c_seg_blank = 7'h7F;

    // Two-requester round robin: with both requesting, the one not granted
    // last wins; otherwise the only requester wins.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
        if (valid == 2'b11) begin
            return ~last_grant;
        end
        return valid[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : BCD nibble to active-low seven-segment pattern. Nibbles
//               above 9, or an asserted blank, produce all segments off.
// Ports       : nibble - BCD digit value
//               blank  - force all segments off
//               seg    - active-low segments, seg[0]=CA .. seg[6]=CG
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = c_seg_blank;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = c_seg_0;
                4'd1:    seg = c_seg_1;
                4'd2:    seg = c_seg_2;
                4'd3:    seg = c_seg_3;
                4'd4:    seg = c_seg_4;
                4'd5:    seg = c_seg_5;
                4'd6:    seg = c_seg_6;
                4'd7:    seg = c_seg_7;
                4'd8:    seg = c_seg_8;
                4'd9:    seg = c_seg_9;
                default: seg = c_seg_blank;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Round-robin arbiter between two BCD display requesters
//               driving a multiplexed 4-digit seven-segment display. A
//               granted value is scanned for at least HOLD_FRAMES full
//               frames; re-arbitration only happens at a frame boundary.
// Parameters  : REFRESH_DIV - clk cycles each digit stays lit (2..65535)
//               HOLD_FRAMES - minimum frames per granted value (1..255)
// Ports       : clk, reset (synchronous, active-high)
//               req_valid[1:0], req_data[31:0] - requests, word i at [16i+:16]
//               req_ready[1:0] - one-cycle accept pulse
//               an[3:0], seg[6:0], dp - active-low display drive
//               grant_id - owner of the displayed value
//               busy - high while granting or showing
// Options     : SEG_BLANK_LEADING_ZERO_EN - blank leading zero digits
//               (digit 0 is always shown)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [1:0]  req_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        grant_id,
    output logic        busy
);

    localparam int               DIV_W      = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(REFRESH_DIV - 1);
    localparam logic [7:0]       c_hold     = 8'(HOLD_FRAMES);

    state_t           r_state,  w_state_nx;
    logic [15:0]      r_disp,   w_disp_nx;
    digit_idx_t       r_digit,  w_digit_nx;
    logic [DIV_W-1:0] r_div,    w_div_nx;
    logic [7:0]       r_frames, w_frames_nx, w_frames_inc;
    logic             r_last,   w_last_nx;
    logic             r_grant_id, w_grant_nx;
    logic             w_pick;

    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [1:0]       r_ready;
    logic             r_busy;

    logic [3:0]       w_nibble;
    logic             w_lz_blank;
    logic [6:0]       w_seg_dec;

    always_comb begin
        w_state_nx   = r_state;
        w_disp_nx    = r_disp;
        w_digit_nx   = r_digit;
        w_div_nx     = r_div;
        w_frames_nx  = r_frames;
        w_last_nx    = r_last;
        w_grant_nx   = r_grant_id;
        w_frames_inc = (r_frames >= c_hold) ? r_frames : r_frames + 8'd1;
        w_pick       = rr_pick(req_valid, r_last);

        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_state_nx = GRANT;
                    w_grant_nx = w_pick;
                    w_last_nx  = w_pick;
                end
            end
            GRANT: begin
                // The transfer completes on this edge, so capture here.
                w_state_nx  = SHOW;
                w_disp_nx   = r_grant_id ? req_data[31:16] : req_data[15:0];
                w_digit_nx  = 2'd3;
                w_div_nx    = '0;
                w_frames_nx = 8'd0;
            end
            SHOW: begin
                if (r_div == c_div_last) begin
                    w_div_nx   = '0;
                    w_digit_nx = r_digit - 2'd1;
                    // Digit 0 finishing closes a frame: the only point where
                    // a new owner may take over.
                    if (r_digit == 2'd0) begin
                        w_frames_nx = w_frames_inc;
                        if ((w_frames_inc >= c_hold) && (|req_valid)) begin
                            w_state_nx = GRANT;
                            w_grant_nx = w_pick;
                            w_last_nx  = w_pick;
                        end
                    end
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so the registered drive
    // lines up with the state it belongs to.
    assign w_nibble = w_disp_nx[{w_digit_nx, 2'b00} +: 4];

`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic w_lz3, w_lz2, w_lz1;
    assign w_lz3 = (w_disp_nx[15:12] == 4'd0);
    assign w_lz2 = w_lz3 && (w_disp_nx[11:8] == 4'd0);
    assign w_lz1 = w_lz2 && (w_disp_nx[7:4] == 4'd0);
    always_comb begin
        case (w_digit_nx)
            2'd3:    w_lz_blank = w_lz3;
            2'd2:    w_lz_blank = w_lz2;
            2'd1:    w_lz_blank = w_lz1;
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_decoder u_seg7_decoder (
        .nibble (w_nibble),
        .blank  ((w_state_nx != SHOW) || w_lz_blank),
        .seg    (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_disp     <= 16'd0;
            r_digit    <= 2'd3;
            r_div      <= '0;
            r_frames   <= 8'd0;
            r_last     <= 1'b1;
            r_grant_id <= 1'b0;
            r_an       <= 4'hF;
            r_seg      <= c_seg_blank;
            r_dp       <= 1'b1;
            r_ready    <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_disp     <= w_disp_nx;
            r_digit    <= w_digit_nx;
            r_div      <= w_div_nx;
            r_frames   <= w_frames_nx;
            r_last     <= w_last_nx;
            r_grant_id <= w_grant_nx;
            r_an       <= (w_state_nx == SHOW) ? ~(4'b0001 << w_digit_nx) : 4'hF;
            r_seg      <= w_seg_dec;
            r_dp       <= 1'b1;
            r_ready    <= (w_state_nx == GRANT) ? (w_grant_nx ? 2'b10 : 2'b01) : 2'b00;
            r_busy     <= (w_state_nx != IDLE);
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign req_ready = r_ready;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Self-checking bench for seg_display_arbiter with
//               REFRESH_DIV=4, HOLD_FRAMES=2. Every clock step pushes the
//               expected registered outputs to a queue; a negedge checker
//               pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    localparam int REFRESH_DIV = 4;
    localparam int HOLD_FRAMES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] req_data = 32'd0;
    logic [1:0]  req_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        grant_id;
    logic        busy;

    seg_display_arbiter #(
        .REFRESH_DIV (REFRESH_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] ready;
        logic       busy;
        logic       gid;
    } out_t;

    typedef struct {
        out_t  o;
        string tag;
    } exp_t;

    typedef struct {
        logic            id;
        logic [15:0]     data;
        logic [3:0][6:0] segs;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic out_t mk(logic [3:0] a, logic [6:0] s, logic [1:0] r, logic b, logic g);
        out_t o;
        o.an = a; o.seg = s; o.dp = 1'b1; o.ready = r; o.busy = b; o.gid = g;
        return o;
    endfunction

    function automatic logic [6:0] seg_of(logic [15:0] v, int d);
        logic [3:0] nib;
        nib = v[4*d +: 4];
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if (d != 0 && (v >> (4*d)) == 16'd0) return 7'h7F;
`endif
        case (nib)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0][6:0] segs_of(logic [15:0] v);
        logic [3:0][6:0] r;
        for (int d = 0; d < 4; d++) r[d] = seg_of(v, d);
        return r;
    endfunction

    // Outputs after the coming active edge must equal e.
    task automatic step(input out_t e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        x.o = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic reset_step();
        reset = 1'b1;
        step(mk(4'hF, 7'h7F, 2'b00, 1'b0, 1'b0), "reset");
        reset = 1'b0;
    endtask

    task automatic grant_step(input logic id);
        step(mk(4'hF, 7'h7F, id ? 2'b10 : 2'b01, 1'b1, id), "grant");
    endtask

    // Scan cycles from the start of a frame; after cycle chg_at the inputs
    // switch to vld/dat (chg_at=0 is the cycle right after acceptance).
    task automatic show(input logic [3:0][6:0] segs, input logic gid, input int ncyc,
                        input int chg_at, input logic [1:0] vld, input logic [31:0] dat);
        int d;
        logic [3:0] a;
        for (int i = 0; i < ncyc; i++) begin
            d = 3 - ((i / REFRESH_DIV) % 4);
            a = 4'b0001 << d;
            step(mk(~a, segs[d], 2'b00, 1'b1, gid), "show");
            if (i == chg_at) begin
                req_valid = vld;
                req_data  = dat;
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            out_t act;
            e = sb.pop_front();
            act = {an, seg, dp, req_ready, busy, grant_id};
            n_vec++;
            if (act !== e.o) begin
                n_bad++;
                $display("FAIL %s @%0t: got an=%b seg=%h dp=%b ready=%b busy=%b gid=%b, want an=%b seg=%h dp=%b ready=%b busy=%b gid=%b",
                         e.tag, $time, act.an, act.seg, act.dp, act.ready, act.busy, act.gid,
                         e.o.an, e.o.seg, e.o.dp, e.o.ready, e.o.busy, e.o.gid);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        vt[0] = '{1'b0, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
        vt[1] = '{1'b1, 16'h5678, {7'h12, 7'h02, 7'h78, 7'h00}};
        vt[2] = '{1'b0, 16'h90AF, {7'h10, 7'h40, 7'h7F, 7'h7F}};
`ifdef SEG_BLANK_LEADING_ZERO_EN
        vt[3] = '{1'b1, 16'h0A07, {7'h7F, 7'h7F, 7'h40, 7'h78}};
        vt[4] = '{1'b0, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
        vt[3] = '{1'b1, 16'h0A07, {7'h40, 7'h7F, 7'h40, 7'h78}};
        vt[4] = '{1'b0, 16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif

        // Single requester: latency, word select, decode, one frame plus wrap.
        for (int k = 0; k < 5; k++) begin
            req_valid = 2'b00;
            reset_step();
            req_data  = vt[k].id ? {vt[k].data, ~vt[k].data} : {~vt[k].data, vt[k].data};
            req_valid = vt[k].id ? 2'b10 : 2'b01;
            grant_step(vt[k].id);
            show(vt[k].segs, vt[k].id, 20, 0, 2'b00, req_data);
        end

        // Both requesting continuously: alternate every HOLD_FRAMES frames.
        req_valid = 2'b00;
        reset_step();
        req_data  = {16'h5678, 16'h1234};
        req_valid = 2'b11;
        grant_step(1'b0);
        show(segs_of(16'h1234), 1'b0, 32, 0, 2'b11, {16'h5678, 16'h4321});
        grant_step(1'b1);
        show(segs_of(16'h5678), 1'b1, 32, 0, 2'b11, {16'h8765, 16'h4321});
        grant_step(1'b0);
        show(segs_of(16'h4321), 1'b0, 16, 0, 2'b00, {16'h8765, 16'h4321});

        // Request arriving mid-frame 3 waits for the frame boundary.
        req_valid = 2'b00;
        reset_step();
        req_data  = {16'h0000, 16'h1234};
        req_valid = 2'b01;
        grant_step(1'b0);
        show(segs_of(16'h1234), 1'b0, 32, 0, 2'b00, {16'h0000, 16'h1234});
        show(segs_of(16'h1234), 1'b0, 16, 5, 2'b10, {16'h9876, 16'h1234});
        grant_step(1'b1);
        show(segs_of(16'h9876), 1'b1, 16, 0, 2'b00, {16'h9876, 16'h1234});

        // Reset during GRANT and during SHOW with the request held.
        req_valid = 2'b00;
        reset_step();
        req_data  = {16'h0000, 16'h0A07};
        req_valid = 2'b01;
        grant_step(1'b0);
        reset_step();
        grant_step(1'b0);
        show(segs_of(16'h0A07), 1'b0, 6, -1, 2'b01, req_data);
        reset_step();
        grant_step(1'b0);
        show(segs_of(16'h0A07), 1'b0, 16, 0, 2'b00, req_data);

        // No further requests: value retained for 100 frames.
        req_valid = 2'b00;
        reset_step();
        req_data  = {16'h0042, 16'hFFFF};
        req_valid = 2'b10;
        grant_step(1'b1);
        show(segs_of(16'h0042), 1'b1, 100 * 4 * REFRESH_DIV, 0, 2'b00, req_data);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
